// File: rtl/axis_token_bucket_shaper_if.sv
// axis_token_bucket_shaper_if: AXI4-Stream channel bundle used on both sides of the shaper.
//   tdata/tstrb/tuser/tvalid/tlast travel from master to slave; tready travels back.
//   master modport: the stream source; slave modport: the stream sink.
interface axis_token_bucket_shaper_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_token_bucket_shaper.sv
// axis_token_bucket_shaper: packet-granular token-bucket shaper on one AXI4-Stream channel.
//   axi_aclk, axi_aresetn : clock, asynchronous active-low reset
//   s_axis (slave)        : incoming packets, tuser[15:0] = length in bytes on the first beat
//   m_axis (master)       : admitted packets, passed through combinationally
//   enable                : 1 = token check and debit, 0 = admit everything
//   rate_tokens/interval  : tokens added every max(rate_interval,1) cycles
//   bucket_max            : bucket depth in bytes
//   sw_rst                : synchronous flush of counters and any packet in flight
//   tokens, pkt_count, stall_cycles : status
module axis_token_bucket_shaper #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TOKEN_WIDTH        = 24,
    parameter int C_RATE_WIDTH         = 16
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    axis_token_bucket_shaper_if.slave     s_axis,
    axis_token_bucket_shaper_if.master    m_axis,
    input  logic                          enable,
    input  logic [C_RATE_WIDTH-1:0]       rate_tokens,
    input  logic [C_RATE_WIDTH-1:0]       rate_interval,
    input  logic [C_TOKEN_WIDTH-1:0]      bucket_max,
    input  logic                          sw_rst,
    output logic [C_TOKEN_WIDTH-1:0]      tokens,
    output logic [31:0]                   pkt_count,
    output logic [31:0]                   stall_cycles
);
    typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;
    state_t                   state, state_next;
    logic [C_RATE_WIDTH-1:0]  refill_cnt;
    logic [C_TOKEN_WIDTH-1:0] len_ext, need, debit, tokens_next;
    logic [C_TOKEN_WIDTH:0]   sum;
    logic                     refill, admit, stall, s_ready, m_valid, last_beat;

    assign len_ext = C_TOKEN_WIDTH'(s_axis.tuser[15:0]);
    // Oversize packets only need a full bucket, so they cannot starve forever.
    assign need    = (len_ext > bucket_max) ? bucket_max : len_ext;
    assign admit   = state == IDLE && s_axis.tvalid && !sw_rst && (!enable || tokens >= need);
    assign stall   = state == IDLE && s_axis.tvalid && enable && !admit;
    assign debit   = (admit && enable) ? need : '0;
    // >= rather than == so a shrinking interval cannot strand the counter above the wrap point.
    assign refill  = refill_cnt >= ((rate_interval == '0) ? '0 : rate_interval - 1'b1);
    // One spare bit keeps tokens + refill from wrapping before the saturation compare.
    assign sum         = {1'b0, tokens} - {1'b0, debit} + (refill ? (C_TOKEN_WIDTH+1)'(rate_tokens) : '0);
    assign tokens_next = (sum > {1'b0, bucket_max}) ? bucket_max : sum[C_TOKEN_WIDTH-1:0];

    always_comb begin
        state_next = state;
        s_ready    = (state == SEND) ? m_axis.tready : (state == FLUSH);
        m_valid    = (state == SEND) && s_axis.tvalid;
        last_beat  = s_axis.tvalid && s_ready && s_axis.tlast;
        case (state)
            IDLE:    state_next = admit ? SEND : IDLE;
            // A packet whose tlast completes in the flush cycle is whole, so there is nothing to drop.
            SEND:    state_next = last_beat ? IDLE : (sw_rst ? FLUSH : SEND);
            FLUSH:   state_next = last_beat ? IDLE : FLUSH;
            default: state_next = IDLE;
        endcase
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tlast  = (state == SEND) && s_axis.tlast;
    assign m_axis.tdata  = C_M_AXIS_DATA_WIDTH'(s_axis.tdata[C_S_AXIS_DATA_WIDTH-1:0]);
    assign m_axis.tstrb  = (C_M_AXIS_DATA_WIDTH/8)'(s_axis.tstrb[C_S_AXIS_DATA_WIDTH/8-1:0]);
    assign m_axis.tuser  = C_M_AXIS_TUSER_WIDTH'(s_axis.tuser[C_S_AXIS_TUSER_WIDTH-1:0]);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state        <= IDLE;
            tokens       <= '0;
            refill_cnt   <= '0;
            pkt_count    <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if (sw_rst) begin
                tokens       <= '0;
                refill_cnt   <= '0;
                pkt_count    <= '0;
                stall_cycles <= '0;
            end else begin
                tokens       <= tokens_next;
                refill_cnt   <= refill ? '0 : refill_cnt + 1'b1;
                pkt_count    <= pkt_count + 32'(admit);
                stall_cycles <= stall_cycles + 32'(stall);
            end
        end
    end
endmodule

// File: tb/tb_axis_token_bucket_shaper.sv
// tb_axis_token_bucket_shaper: directed self-checking bench for axis_token_bucket_shaper.
module tb_axis_token_bucket_shaper;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable, sw_rst;
    logic [15:0] rate_tokens, rate_interval;
    logic [23:0] bucket_max, maxv;
    logic [23:0] tokens;
    logic [31:0] pkt_count, stall_cycles;
    logic [15:0] pat = 16'hB2D6;
    logic [32:0] rx_q[$], exp_q[$];
    int          rx_cyc[$];
    int          cyc, checks, errors, bp_err, start;

    axis_token_bucket_shaper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_axis ();
    axis_token_bucket_shaper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_axis ();

    axis_token_bucket_shaper dut (
        .axi_aclk(clk), .axi_aresetn(rst_n), .s_axis(s_axis), .m_axis(m_axis),
        .enable(enable), .rate_tokens(rate_tokens), .rate_interval(rate_interval),
        .bucket_max(bucket_max), .sw_rst(sw_rst), .tokens(tokens),
        .pkt_count(pkt_count), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        if (m_axis.tvalid && m_axis.tready) begin
            rx_q.push_back({m_axis.tlast, m_axis.tdata[31:0]});
            rx_cyc.push_back(cyc);
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int len, input int data, input bit last);
        s_axis.tvalid = 1'b1;
        s_axis.tuser  = 128'(len);
        s_axis.tdata  = 256'(data);
        s_axis.tlast  = last;
    endtask

    task automatic expect_pkt(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, 32'(base + i)});
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_beats"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) chk({tag, "_beat"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
        rx_cyc.delete();
    endtask

    // Presents n beats back to back; bp toggles m_axis.tready from a fixed pattern.
    task automatic send_pkt(input int len, input int n, input int base, input bit bp);
        int  i = 0;
        int  guard = 0;
        bit  acc;
        while (i < n && guard < 500) begin
            drive(len, base + i, i == n - 1);
            if (bp) m_axis.tready = pat[guard % 16];
            @(negedge clk);
            acc = s_axis.tready;
            if (m_axis.tvalid && s_axis.tready !== m_axis.tready) bp_err++;
            tick();
            if (acc) i++;
            guard++;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        m_axis.tready = 1'b1;
        chk("send_done", i, n);
    endtask

    initial begin
        enable = 1'b0; sw_rst = 1'b0; rate_tokens = 16'd0; rate_interval = 16'd1; bucket_max = 24'd1000;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tdata = '0; s_axis.tuser = '0; s_axis.tstrb = '1;
        m_axis.tready = 1'b1;
        #3;
        chk("rst_tokens", tokens, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_m_tvalid", m_axis.tvalid, 0);
        chk("rst_s_tready", s_axis.tready, 0);
        chk("rst_m_tlast", m_axis.tlast, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // shaping off: three 2-beat packets back to back
        start = cyc;
        send_pkt(64, 2, 'h100, 0);
        send_pkt(64, 2, 'h200, 0);
        send_pkt(64, 2, 'h300, 0);
        tick();
        chk("bypass_latency", rx_cyc[0], start + 1);
        chk("bypass_no_bubble", rx_cyc[1], rx_cyc[0] + 1);
        chk("bypass_gap1", rx_cyc[2] - rx_cyc[1], 2);
        chk("bypass_gap2", rx_cyc[4] - rx_cyc[3], 2);
        chk("bypass_pkt_count", pkt_count, 3);
        chk("bypass_tokens", tokens, 0);
        expect_pkt('h100, 2); expect_pkt('h200, 2); expect_pkt('h300, 2);
        check_rx("bypass");

        // 500-byte packet waits for 5 refills of 100 every 10 cycles
        enable = 1'b1; rate_tokens = 16'd100; rate_interval = 16'd10; sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("swrst_tokens", tokens, 0);
        chk("swrst_pkt_count", pkt_count, 0);
        drive(500, 'h500, 0);
        repeat (50) tick();
        chk("wait_tokens", tokens, 500);
        chk("wait_stall", stall_cycles, 50);
        chk("wait_s_tready", s_axis.tready, 0);
        tick();
        chk("admit_tokens", tokens, 0);
        chk("admit_pkt_count", pkt_count, 1);
        chk("admit_m_tvalid", m_axis.tvalid, 1);
        chk("admit_m_tdata", m_axis.tdata[31:0], 'h500);
        chk("admit_s_tready", s_axis.tready, 1);
        tick();
        drive(500, 'h501, 1);
        tick();
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        chk("after_pkt_s_tready", s_axis.tready, 0);
        chk("after_pkt_stall", stall_cycles, 50);
        expect_pkt('h500, 2);
        check_rx("rate");

        // saturation, then clamp on a lowered bucket_max
        maxv = '0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (tokens > maxv) maxv = tokens;
        end
        chk("sat_tokens", tokens, 1000);
        chk("sat_max_seen", maxv, 1000);
        bucket_max = 24'd300;
        tick();
        chk("clamp_tokens", tokens, 300);

        // oversize packet admitted on a full 256-byte bucket
        bucket_max = 24'd256; rate_tokens = 16'd64; sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        drive(1500, 'h1500, 1);
        repeat (40) tick();
        chk("over_full_tokens", tokens, 256);
        chk("over_wait_s_tready", s_axis.tready, 0);
        tick();
        chk("over_admit_tokens", tokens, 0);
        chk("over_admit_s_tready", s_axis.tready, 1);
        chk("over_pkt_count", pkt_count, 1);
        chk("over_stall", stall_cycles, 40);
        tick();
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        expect_pkt('h1500, 1);
        check_rx("oversize");

        // backpressure during a 6-beat packet
        enable = 1'b0; bp_err = 0;
        send_pkt(192, 6, 'h600, 1);
        tick();
        chk("bp_tready_track", bp_err, 0);
        expect_pkt('h600, 6);
        check_rx("backpressure");

        // sw_rst on beat 2 of 4: beats 3-4 dropped, next packet normal
        drive(128, 'h700, 0);
        tick();
        chk("flush_admit_s_tready", s_axis.tready, 1);
        tick();
        drive(128, 'h701, 0);
        sw_rst = 1'b1;
        chk("flush_beat2_m_tvalid", m_axis.tvalid, 1);
        tick();
        sw_rst = 1'b0;
        drive(128, 'h702, 0);
        chk("flush_beat3_m_tvalid", m_axis.tvalid, 0);
        chk("flush_beat3_s_tready", s_axis.tready, 1);
        chk("flush_tokens", tokens, 0);
        chk("flush_pkt_count", pkt_count, 0);
        chk("flush_stall", stall_cycles, 0);
        tick();
        drive(128, 'h703, 1);
        chk("flush_beat4_m_tvalid", m_axis.tvalid, 0);
        tick();
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        chk("flush_done_s_tready", s_axis.tready, 0);
        send_pkt(64, 2, 'h800, 0);
        tick();
        chk("flush_next_pkt_count", pkt_count, 1);
        exp_q.push_back({1'b0, 32'h700});
        exp_q.push_back({1'b0, 32'h701});
        expect_pkt('h800, 2);
        check_rx("flush");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_token_bucket_shaper.md
# axis_token_bucket_shaper

Packet-granular token-bucket rate shaper on a single AXI4-Stream channel. It sits between a per-port arbiter output and the MAC/TX queue of an OSNT generator port. It admits a whole packet only when the bucket holds enough byte tokens for that packet's length. Once admitted, the packet passes through unmodified with full backpressure, and the block refills tokens at a programmed rate.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master tdata width (must equal slave width)
- C_S_AXIS_DATA_WIDTH, 256, slave tdata width
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; tuser[15:0] = packet length in bytes, valid on first beat
- C_TOKEN_WIDTH, 24, token counter / bucket_max width
- C_RATE_WIDTH, 16, rate_tokens and rate_interval width
- axi_aclk  in  1  sole clock
- axi_aresetn  in  1  asynchronous, active-low reset
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  per widths  slave stream
- s_axis_tready  out  1  slave ready
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  per widths  master stream
- m_axis_tready  in  1  master ready
- enable  in  1  1 = shaping on; 0 = packets admitted without token check or debit
- rate_tokens  in  C_RATE_WIDTH  tokens (bytes) added per refill event
- rate_interval  in  C_RATE_WIDTH  cycles between refill events; 0 treated as 1
- bucket_max  in  C_TOKEN_WIDTH  bucket depth in bytes
- sw_rst  in  1  synchronous soft reset / flush
- tokens  out  C_TOKEN_WIDTH  current token count
- pkt_count  out  32  packets admitted, wrapping
- stall_cycles  out  32  cycles spent in IDLE with s_axis_tvalid=1 and admission refused, wrapping

## Operation
- States: IDLE, SEND, FLUSH. Reset state IDLE.
- In IDLE:
  - s_axis_tready=0, m_axis_tvalid=0.
  - Let len = s_axis_tuser[15:0] and need = min(len, bucket_max).
  - Admit when s_axis_tvalid=1 and (enable=0 or tokens >= need).
  - On admit, next state is SEND; if enable=1, debit need at the same edge. pkt_count increments.
- len=0 is admitted immediately with zero debit.
- len > bucket_max is admitted once tokens == bucket_max, and the bucket is emptied.
- In SEND:
  - m_axis_* = s_axis_* combinationally, except m_axis_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_tready.
  - On a beat with tlast=1, tvalid=1 and tready=1, return to IDLE.
- In FLUSH: s_axis_tready=1 and m_axis_tvalid=0. Beats are discarded until a tlast handshake, then the state goes to IDLE.
- Refill:
  - A cycle counter runs 0..max(rate_interval,1)-1; a refill event occurs on wrap.
  - tokens_next = min(tokens - debit + add, bucket_max), where add = rate_tokens on a refill event, else 0.
  - Compute with C_TOKEN_WIDTH+1 bits, then saturate.
- Refill continues in all states and regardless of enable.
- If bucket_max is lowered below tokens, tokens clamps to bucket_max on the next edge.
- sw_rst=1:
  - tokens, refill counter, pkt_count and stall_cycles clear.
  - From SEND, the state goes to FLUSH, so the partial packet is dropped downstream-side, with no further m_axis_tvalid.
  - From IDLE or FLUSH, the state stays or goes to IDLE or FLUSH respectively.
  - sw_rst has priority over admit and refill.
- stall_cycles increments in IDLE when s_axis_tvalid=1, enable=1 and the packet is not admitted.

## Timing
- Reset (axi_aresetn=0, asynchronous): state IDLE, tokens=0, counters=0. Outputs m_axis_tvalid=0, s_axis_tready=0, m_axis_tlast=0; data outputs are don't-care.
- Admission latency: first beat presented in IDLE with enough tokens appears on m_axis with tvalid=1 exactly 1 cycle later. No bubbles thereafter while both sides are ready.
- Back-to-back packets: 1 idle cycle between the tlast beat and the next packet's first beat (IDLE decision cycle).
- The token comparison uses the registered tokens value; a refill in the admit cycle is not visible to that cycle's check.
- Data path has no registers: zero latency inside SEND.

## Test plan
- enable=0, three 64-byte packets of 2 beats each, m_axis_tready=1 -> all pass in order; pkt_count=3; tokens unchanged apart from refill; 1-cycle gap between packets.
- enable=1, bucket_max=1000, rate_tokens=100, rate_interval=10, start empty, one 500-byte packet waiting -> admitted at the first cycle tokens>=500 (~50 cycles), tokens drops by 500 on the admit edge; stall_cycles matches the wait.
- Saturation: idle 10,000 cycles with bucket_max=1000 -> tokens=1000, never exceeds it; then lower bucket_max to 300 -> tokens=300 next cycle.
- Oversize: bucket_max=256, len=1500 -> admitted when tokens=256; tokens becomes 0 (plus any refill in the same cycle).
- Backpressure: random m_axis_tready during SEND -> no beat lost or duplicated; s_axis_tready tracks m_axis_tready.
- sw_rst asserted mid-packet (beat 2 of 4) -> m_axis_tvalid=0 from the next cycle; beats 3–4 are consumed and dropped; tokens=0, pkt_count=0; the next packet is handled normally.
